// File: rtl/slice_sched_pkg.sv
// Shared types and width helpers for the time-sliced round-robin scheduler.
//   state_e  : scheduler FSM states
//   width_of : max(1, $clog2(x)), the width of an index or counter over x values
package slice_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HANDOFF = 2'd2
  } state_e;

  // A single-value range still needs a 1-bit field.
  function automatic int unsigned width_of(input int unsigned x);
    return (x <= 32'd2) ? 32'd1 : 32'($clog2(x));
  endfunction

endpackage

// File: rtl/slice_rr_scheduler_rr_pick.sv
// Round-robin request picker (combinational).
//   req : per-requester request vector
//   ptr : highest-priority index for this pick
//   idx : first requester at or above ptr, wrapping to 0 if none above
//   any : at least one request is present
module rr_pick
  import slice_sched_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]           req,
  input  logic [width_of(N)-1:0] ptr,
  output logic [width_of(N)-1:0] idx,
  output logic                   any
);

  localparam int unsigned IW = width_of(N);

  logic          hi_hit;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;

  // Scan downward so the last hit written is the lowest index:
  // lo_idx is the lowest request overall, hi_idx the lowest at/above ptr.
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IW'(i);
        if (IW'(i) >= ptr) begin
          hi_hit = 1'b1;
          hi_idx = IW'(i);
        end
      end
    end
  end

  assign idx = hi_hit ? hi_idx : lo_idx;
  assign any = |req;

endmodule

// File: rtl/slice_rr_scheduler.sv
// Time-sliced round-robin arbiter for one shared datapath resource.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : allows new grants; low lets the current owner finish
//   req        : per-requester level request
//   gnt        : registered one-hot grant, zero when no owner
//   gnt_vld    : registered, |gnt
//   gnt_id     : registered owner index, zero when no owner
//   slice_cnt  : registered cycles already used by the owner
//   expire     : combinational, high during the owner's last permitted cycle
module slice_rr_scheduler
  import slice_sched_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned SLICE = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [N-1:0]               req,
  output logic [N-1:0]               gnt,
  output logic                       gnt_vld,
  output logic [width_of(N)-1:0]     gnt_id,
  output logic [width_of(SLICE)-1:0] slice_cnt,
  output logic                       expire
);

  localparam int unsigned   IW      = width_of(N);
  localparam int unsigned   CW      = width_of(SLICE);
  localparam logic [CW-1:0] LAST    = CW'(SLICE - 1);
  localparam logic [IW-1:0] LAST_ID = IW'(N - 1);
  localparam logic [N-1:0]  ONE     = N'(1);

  state_e        state;
  state_e        state_d;
  logic [N-1:0]  gnt_d;
  logic [IW-1:0] gnt_id_d;
  logic [CW-1:0] cnt_d;
  logic          vld_d;
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] pick_idx;
  logic          any;
  logic          owner_req;
  logic          at_last;

  rr_pick #(.N(N)) u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (any)
  );

  assign owner_req = req[gnt_id];
  assign at_last   = (slice_cnt == LAST);

  // A release in the last cycle wins over expiry, so expire stays low then.
  assign expire = (state == GRANT) && owner_req && at_last;

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    gnt_d    = gnt;
    gnt_id_d = gnt_id;
    cnt_d    = slice_cnt;
    vld_d    = gnt_vld;
    ptr_d    = ptr;
    case (state)
      IDLE, HANDOFF: begin
        if (enable && any) begin
          state_d  = GRANT;
          gnt_d    = ONE << pick_idx;
          gnt_id_d = pick_idx;
          cnt_d    = '0;
          vld_d    = 1'b1;
        end else begin
          state_d  = IDLE;
          gnt_d    = '0;
          gnt_id_d = '0;
          cnt_d    = '0;
          vld_d    = 1'b0;
        end
      end
      GRANT: begin
        if (!owner_req || at_last) begin
          state_d  = HANDOFF;
          gnt_d    = '0;
          gnt_id_d = '0;
          cnt_d    = '0;
          vld_d    = 1'b0;
          ptr_d    = (gnt_id == LAST_ID) ? '0 : gnt_id + IW'(1);
        end else begin
          cnt_d = slice_cnt + CW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
        cnt_d    = '0;
        vld_d    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_vld   <= 1'b0;
      gnt_id    <= '0;
      slice_cnt <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_d;
      gnt       <= gnt_d;
      gnt_vld   <= vld_d;
      gnt_id    <= gnt_id_d;
      slice_cnt <= cnt_d;
      ptr       <= ptr_d;
    end
  end

endmodule

// File: tb/tb_slice_rr_scheduler.sv
// Bench for slice_rr_scheduler: instance a (N=4, SLICE=8) and instance b (N=4, SLICE=1),
// checked against a cycle model through an expectation queue.
module tb_slice_rr_scheduler;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, en_a, en_b;
  logic [3:0] req_a, req_b;
  logic [3:0] gnt_a, gnt_b;
  logic       vld_a, vld_b;
  logic [1:0] id_a, id_b;
  logic [2:0] cnt_a;
  logic [0:0] cnt_b;
  logic       exp_a, exp_b;

  slice_rr_scheduler #(.N(4), .SLICE(8)) u_a (
    .clk(clk), .rst_n(rst_a), .enable(en_a), .req(req_a),
    .gnt(gnt_a), .gnt_vld(vld_a), .gnt_id(id_a), .slice_cnt(cnt_a), .expire(exp_a)
  );

  slice_rr_scheduler #(.N(4), .SLICE(1)) u_b (
    .clk(clk), .rst_n(rst_b), .enable(en_b), .req(req_b),
    .gnt(gnt_b), .gnt_vld(vld_b), .gnt_id(id_b), .slice_cnt(cnt_b), .expire(exp_b)
  );

  typedef struct {
    int         d;
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] id;
    logic [2:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state, one slot per instance.
  int   m_slice[2] = '{8, 1};
  bit   m_busy[2];
  int   m_owner[2];
  int   m_used[2];
  int   m_ptr[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cur_req(input int d);
    return (d == 0) ? req_a : req_b;
  endfunction

  function automatic logic cur_en(input int d);
    return (d == 0) ? en_a : en_b;
  endfunction

  function automatic logic cur_rst(input int d);
    return (d == 0) ? rst_a : rst_b;
  endfunction

  function automatic logic model_expire(input int d);
    logic [3:0] r;
    r = cur_req(d);
    return m_busy[d] && r[2'(m_owner[d])] && (m_used[d] == m_slice[d] - 1);
  endfunction

  task automatic model_reset(input int d);
    m_busy[d]  = 1'b0;
    m_owner[d] = 0;
    m_used[d]  = 0;
    m_ptr[d]   = 0;
  endtask

  // Advance one clock edge and queue the outputs expected after it.
  task automatic model_adv(input int d);
    logic [3:0] r;
    exp_t       e;
    r = cur_req(d);
    if (!cur_rst(d)) begin
      model_reset(d);
    end else if (m_busy[d]) begin
      if (!r[2'(m_owner[d])] || m_used[d] == m_slice[d] - 1) begin
        m_busy[d] = 1'b0;
        m_ptr[d]  = (m_owner[d] + 1) % 4;
      end else begin
        m_used[d]++;
      end
    end else if (cur_en(d) && r != 4'b0000) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr[d] + k) % 4;
        if (r[2'(j)]) begin
          m_owner[d] = j;
          break;
        end
      end
      m_busy[d] = 1'b1;
      m_used[d] = 0;
    end
    e.d   = d;
    e.vld = m_busy[d];
    e.gnt = m_busy[d] ? (4'b0001 << m_owner[d]) : 4'b0000;
    e.id  = m_busy[d] ? 2'(m_owner[d]) : 2'd0;
    e.cnt = m_busy[d] ? 3'(m_used[d]) : 3'd0;
    sbq.push_back(e);
  endtask

  // One cycle: check expire mid-cycle, queue expectations, then pop and compare after the edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    chk("expire_a", 32'(exp_a), 32'(model_expire(0)));
    chk("expire_b", 32'(exp_b), 32'(model_expire(1)));
    model_adv(0);
    model_adv(1);
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.d == 0) begin
        chk("gnt_a", 32'(gnt_a), 32'(e.gnt));
        chk("vld_a", 32'(vld_a), 32'(e.vld));
        chk("id_a",  32'(id_a),  32'(e.id));
        chk("cnt_a", 32'(cnt_a), 32'(e.cnt));
      end else begin
        chk("gnt_b", 32'(gnt_b), 32'(e.gnt));
        chk("vld_b", 32'(vld_b), 32'(e.vld));
        chk("id_b",  32'(id_b),  32'(e.id));
        chk("cnt_b", 32'(cnt_b), 32'(e.cnt));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   run, best, found;
    int   ord[$];
    logic prev_vld;

    // Reset with all requests high: outputs stay at reset values.
    rst_a = 1'b0; rst_b = 1'b0;
    en_a  = 1'b1; en_b  = 1'b0;
    req_a = 4'hF; req_b = 4'h0;
    model_reset(0);
    model_reset(1);
    repeat (3) step();
    chk("rst_expire", 32'(exp_a), 32'd0);
    rst_a = 1'b1;
    step();
    chk("first_gnt", 32'(gnt_a), 32'h1);
    step();

    // Sole persistent requester 2: 8-cycle slices separated by one gap.
    req_a = 4'b0100;
    run = 0; best = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (gnt_a == 4'b0100) begin
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
    end
    chk("t2_slice_len", 32'(best), 32'd8);

    // All requesting: ownership rotates in index order.
    req_a = 4'hF;
    prev_vld = vld_a;
    for (int c = 0; c < 45; c++) begin
      step();
      if (vld_a && !prev_vld) ord.push_back(int'(id_a));
      prev_vld = vld_a;
    end
    chk("t3_ngrants", 32'(ord.size() >= 5), 32'd1);
    if (ord.size() >= 5)
      for (int i = 0; i < 4; i++)
        chk("t3_rr_order", 32'(ord[i+1]), 32'((ord[i] + 1) % 4));

    // Owner 1 releases early while 3 waits.
    req_a = 4'b0000;
    repeat (3) step();
    req_a = 4'b0010;
    found = 0;
    for (int c = 0; c < 12 && found == 0; c++) begin
      step();
      if (gnt_a == 4'b0010) found = 1;
    end
    chk("t4_wait_own1", 32'(found), 32'd1);
    req_a = 4'b1010;
    repeat (2) step();
    req_a = 4'b1000;
    step();
    chk("t4_release_gap", 32'(gnt_a), 32'h0);
    step();
    chk("t4_next_owner", 32'(gnt_a), 32'h8);
    chk("t4_next_cnt", 32'(cnt_a), 32'd0);

    // Drain: owner 0 finishes its slice with enable low, then nothing is granted.
    req_a = 4'b0001;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      step();
      if (gnt_a == 4'b0001) found = 1;
    end
    chk("t5_wait_own0", 32'(found), 32'd1);
    req_a = 4'hF;
    en_a  = 1'b0;
    repeat (14) step();
    chk("t5_drained", 32'(gnt_a), 32'h0);
    en_a = 1'b1;
    step();
    chk("t5_regrant", 32'(gnt_a), 32'h2);

    // SLICE=1 instance: alternating one-cycle grants, then async reset mid-grant.
    req_a = 4'b0000;
    en_a  = 1'b0;
    rst_b = 1'b1;
    en_b  = 1'b1;
    req_b = 4'b0011;
    repeat (6) step();
    found = 0;
    for (int c = 0; c < 4 && found == 0; c++) begin
      step();
      if (gnt_b == 4'b0010) found = 1;
    end
    chk("t6_wait_grant", 32'(found), 32'd1);
    rst_b = 1'b0;
    #2;
    chk("t6_async_gnt", 32'(gnt_b), 32'h0);
    chk("t6_async_vld", 32'(vld_b), 32'd0);
    chk("t6_async_id",  32'(id_b),  32'd0);
    chk("t6_async_exp", 32'(exp_b), 32'd0);
    model_reset(1);
    repeat (2) step();
    rst_b = 1'b1;
    step();
    chk("t6_post_rst", 32'(gnt_b), 32'h1);
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/slice_rr_scheduler.md
Name: slice_rr_scheduler

Overview:
Time-sliced round-robin arbiter that shares one datapath resource among N requesters. A registered one-hot grant is held by one owner for at most SLICE cycles, measured by an internal mod-SLICE slice counter. On expiry or release, ownership passes to the next requester in round-robin order after one dead cycle. It sits in front of the shared resource and drives its enable/select.

Parameters:
N, 4, number of requesters; must be >= 2.
SLICE, 8, maximum consecutive grant cycles per ownership; must be >= 1.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
enable  in  1  allows new grants; low = drain, current owner finishes.
req  in  N  per-requester request, level, held while service wanted.
gnt  out  N  registered one-hot grant; all zero when no owner.
gnt_vld  out  1  registered; equals |gnt.
gnt_id  out  max(1,$clog2(N))  registered index of the owner; 0 when gnt_vld=0.
slice_cnt  out  max(1,$clog2(SLICE))  cycles already consumed by the owner (0 on first granted cycle).
expire  out  1  combinational pulse during the owner's last permitted cycle.

Behaviour:
- Reset (async): state=IDLE, gnt=0, gnt_vld=0, gnt_id=0, slice_cnt=0, rr pointer ptr=0; expire=0.
- States: IDLE, GRANT, HANDOFF.
- Pick: first index i with req[i]=1, searching from ptr upward and wrapping mod N; "any" = |req.
- IDLE: on an edge with enable & any -> GRANT, gnt<=onehot(pick), gnt_id<=pick, slice_cnt<=0. Latency req->gnt = 1 cycle.
- GRANT, per edge, checked in priority order:
  - if !req[gnt_id] -> HANDOFF, gnt<=0, slice_cnt<=0, ptr<=(gnt_id+1) mod N. The release takes priority over expiry in the same cycle; expire is not asserted.
  - else if slice_cnt==SLICE-1 -> HANDOFF, gnt<=0, slice_cnt<=0, ptr<=(gnt_id+1) mod N.
  - else slice_cnt<=slice_cnt+1.
- expire = (state==GRANT) & req[gnt_id] & (slice_cnt==SLICE-1).
- An owner therefore holds gnt for at most SLICE consecutive cycles.
- HANDOFF: exactly one cycle with gnt=0. On the next edge:
  - if enable & any -> GRANT with the pick from the updated ptr.
  - else -> IDLE.
- A sole persistent requester is re-granted after the gap.
- enable low in GRANT does not cut the current owner.
- SLICE=1: every grant lasts one cycle and expire is asserted on it.
- Width rules: slice_cnt never exceeds SLICE-1 and never wraps past it. ptr wraps N-1 -> 0.
- Requests asserted or dropped by non-owners during GRANT have no effect until HANDOFF.
- Reset mid-operation: all outputs go to reset values immediately, not waiting for clk.

Decomposition:
- Package slice_sched_pkg: state_e enum (IDLE, GRANT, HANDOFF), and a width helper function returning max(1,$clog2(x)).
- Sub-module rr_pick: combinational, parameter N; inputs req and ptr; outputs idx and any.
- The FSM, slice counter and output registers stay in slice_rr_scheduler.

Test Plan:
1. Reset check, N=4, SLICE=8: assert rst_n low with req=4'hF -> gnt=0, gnt_vld=0, gnt_id=0, slice_cnt=0, expire=0. Release reset -> gnt=4'b0001 one cycle later.
2. req=4'b0100 held -> gnt[2] high for exactly 8 cycles, slice_cnt 0..7, expire on cycle with slice_cnt=7, then 1 gap cycle, then gnt[2] again.
3. req=4'hF held -> grant order 0,1,2,3,0, each 8 cycles, separated by single zero-grant cycles.
4. req[1] owner drops req after 3 granted cycles while req[3] is high -> gnt=0 next cycle, expire never asserted, then gnt=4'b1000 with slice_cnt=0.
5. enable=0 while owner 0 holds with req=4'hF -> owner 0 keeps gnt until expiry, then HANDOFF -> IDLE, gnt stays 0. Set enable=1 -> gnt=4'b0010.
6. SLICE=1, req=4'b0011 -> gnt alternates 0001,0000,0010,0000,... with expire high on every granted cycle. Async reset mid-grant clears gnt without a clk edge.
